uart_tx_scheduler: RTL and testbench



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_scheduler_if.sv | 23 ++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 30 +++
 rtl/uart_tx_scheduler.sv | 121 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding and
// baud code constants understood by the transmitter's baud_select input.
package uart_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GRANT     = 3'd1;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = S_IDLE,
    GRANT     = S_GRANT,
    WRITE     = S_WRITE,
    WAIT_BUSY = S_WAIT_BUSY,
    WAIT_DONE = S_WAIT_DONE
  } state_e;

  localparam logic [2:0] BAUD_300    = 3'b000;
  localparam logic [2:0] BAUD_1200   = 3'b001;
  localparam logic [2:0] BAUD_2400   = 3'b010;
  localparam logic [2:0] BAUD_4800   = 3'b011;
  localparam logic [2:0] BAUD_9600   = 3'b100;
  localparam logic [2:0] BAUD_19200  = 3'b101;
  localparam logic [2:0] BAUD_57600  = 3'b110;
  localparam logic [2:0] BAUD_115200 = 3'b111;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side bus of the UART transmit scheduler. The requesters form the
// master side; the scheduler is the slave that acknowledges and reports.
interface uart_tx_scheduler_if #(parameter int N_REQ = 4) ();

  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ack;
  logic [N_REQ-1:0]   tx_done;
  logic               tx_err;
  logic [2:0]         grant_id;
  logic               sched_busy;

  modport master (
    output req, req_data,
    input  req_ack, tx_done, tx_err, grant_id, sched_busy
  );

  modport slave (
    input  req, req_data,
    output req_ack, tx_done, tx_err, grant_id, sched_busy
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first active request found scanning
// upward from ptr+1 and wrapping modulo N_REQ. ptr itself is checked last,
// so the last-served requester only wins again when nobody else is asking.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [2:0]       grant,
  output logic             valid
);

  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  // Rotating priority scan starting one past the last grant.
  always_comb begin
    grant = 3'd0;
    valid = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!valid && (((req >> ((int'(ptr) + i) % N_REQ)) & ONE) != {N_REQ{1'b0}})) begin
        valid = 1'b1;
        grant = 3'((int'(ptr) + i) % N_REQ);
      end else begin
        valid = valid;
        grant = grant;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among N_REQ byte producers. A round-robin
// winner's byte is captured, written with a one-cycle Tx_WR, and the frame is
// tracked through Tx_BUSY before the next grant. Transmitter configuration is
// only updated while idle so baud rate and enable never change mid-frame.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_tx_scheduler_if.slave    bus,
  input  logic                  enable,
  input  logic [2:0]            baud_cfg,
  output logic [7:0]            Tx_DATA,
  output logic                  Tx_WR,
  output logic                  Tx_EN,
  output logic [2:0]            baud_select,
  input  logic                  Tx_BUSY
);

  localparam int               CNT_W    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [N_REQ-1:0] ONE      = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [2:0]       LAST_IDX = 3'(N_REQ - 1);

  state_e           state_r;
  logic [2:0]       ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [2:0]       grant_s;
  logic             valid_s;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (bus.req),
    .ptr   (ptr_r),
    .grant (grant_s),
    .valid (valid_s)
  );

  // Next value of the Tx_BUSY wait counter.
  always_comb begin
    cnt_next_s = cnt_r + CNT_W'(1);
  end

  // Scheduler FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= IDLE;
      ptr_r           <= LAST_IDX;
      cnt_r           <= {CNT_W{1'b0}};
      bus.req_ack     <= {N_REQ{1'b0}};
      bus.tx_done     <= {N_REQ{1'b0}};
      bus.tx_err      <= 1'b0;
      bus.grant_id    <= LAST_IDX;
      bus.sched_busy  <= 1'b0;
      Tx_DATA         <= 8'h00;
      Tx_WR           <= 1'b0;
      Tx_EN           <= 1'b0;
      baud_select     <= BAUD_300;
    end else begin
      bus.req_ack <= {N_REQ{1'b0}};
      bus.tx_done <= {N_REQ{1'b0}};
      bus.tx_err  <= 1'b0;
      Tx_WR       <= 1'b0;
      case (state_r)
        IDLE: begin
          baud_select <= baud_cfg;
          Tx_EN       <= enable;
          if (enable && valid_s) begin
            bus.grant_id   <= grant_s;
            Tx_DATA        <= 8'(bus.req_data >> (8 * int'(grant_s)));
            bus.req_ack    <= ONE << grant_s;
            bus.sched_busy <= 1'b1;
            state_r        <= GRANT;
          end else begin
            bus.sched_busy <= 1'b0;
            state_r        <= IDLE;
          end
        end
        GRANT: begin
          // Tx_DATA has had a cycle to settle; strobe during WRITE.
          Tx_WR   <= 1'b1;
          state_r <= WRITE;
        end
        WRITE: begin
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (Tx_BUSY) begin
            state_r <= WAIT_DONE;
          end else if (cnt_next_s == CNT_W'(BUSY_TIMEOUT)) begin
            // Transmitter never accepted the frame: report and move on.
            bus.tx_err     <= 1'b1;
            ptr_r          <= bus.grant_id;
            bus.sched_busy <= 1'b0;
            state_r        <= IDLE;
          end else begin
            cnt_r <= cnt_next_s;
          end
        end
        WAIT_DONE: begin
          if (!Tx_BUSY) begin
            bus.tx_done    <= ONE << bus.grant_id;
            ptr_r          <= bus.grant_id;
            bus.sched_busy <= 1'b0;
            state_r        <= IDLE;
          end else begin
            state_r <= WAIT_DONE;
          end
        end
        default: begin
          bus.sched_busy <= 1'b0;
          state_r        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus predicts the grant order
// from round-robin rules and queues expected ack/done/err events; a monitor
// pops and compares whenever the DUT emits one. A small transmitter model
// drives Tx_BUSY and loops written bytes back as rx_data/rx_valid.
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int TO = 16;

  typedef struct packed {
    logic [1:0] kind;   // 0 ack, 1 done, 2 err
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       enable   = 1'b0;
  logic [2:0] baud_cfg = 3'b000;
  logic [7:0] Tx_DATA;
  logic       Tx_WR;
  logic       Tx_EN;
  logic [2:0] baud_select;
  logic       Tx_BUSY;

  uart_tx_scheduler_if #(.N_REQ(N)) sif ();

  uart_tx_scheduler #(.N_REQ(N), .BUSY_TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (sif),
    .enable      (enable),
    .baud_cfg    (baud_cfg),
    .Tx_DATA     (Tx_DATA),
    .Tx_WR       (Tx_WR),
    .Tx_EN       (Tx_EN),
    .baud_select (baud_select),
    .Tx_BUSY     (Tx_BUSY)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   mptr = N - 1;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: after Tx_WR, busy rises 1..3 cycles later for 2..8 cycles.
  logic       busy_m   = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  int         pre = 0, len = 0;
  bit         no_busy = 1'b0;
  assign Tx_BUSY = busy_m;

  always @(posedge clk) begin
    if (!reset) begin
      busy_m <= 1'b0; pre <= 0; len <= 0; rx_valid <= 1'b0;
    end else if (Tx_WR) begin
      rx_data  <= Tx_DATA;
      rx_valid <= 1'b1;
      if (!no_busy) begin
        pre <= int'($urandom_range(1, 3));
        len <= int'($urandom_range(2, 8));
      end
    end else begin
      rx_valid <= 1'b0;
      if (pre > 1) pre <= pre - 1;
      else if (pre == 1) begin pre <= 0; busy_m <= 1'b1; end
      else if (busy_m) begin
        if (len > 1) len <= len - 1;
        else busy_m <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Round-robin rule: first set bit strictly after p, wrapping.
  function automatic int next_grant(input logic [N-1:0] mask, input int p);
    for (int i = 1; i <= N; i++) if (mask[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // Monitor / scoreboard.
  int         ack_cyc = 0, wr_cyc = 0;
  logic [7:0] cur_data = 8'h00;
  logic [2:0] busy_baud = 3'b000;
  always @(negedge clk) begin : monitor
    exp_t e;
    int   kind_o, id_o;
    if (reset === 1'b1) begin
      if (sif.req_ack != 4'b0 || sif.tx_done != 4'b0 || sif.tx_err) begin
        chk("exclusive_pulse",
            32'(((sif.req_ack != 4'b0) + (sif.tx_done != 4'b0) + sif.tx_err) <= 1 &&
                $countones(sif.req_ack) <= 1 && $countones(sif.tx_done) <= 1), 32'd1);
        if (sif.req_ack != 4'b0) begin kind_o = 0; id_o = oh_idx(sif.req_ack); end
        else if (sif.tx_done != 4'b0) begin kind_o = 1; id_o = oh_idx(sif.tx_done); end
        else begin kind_o = 2; id_o = int'(sif.grant_id); end
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: kind=%0d id=%0d, required no event (cycle %0d)", kind_o, id_o, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", 32'(kind_o), 32'(e.kind));
          chk("event_id", 32'(id_o), 32'(e.id));
          if (kind_o == 0) begin
            chk("tx_data", 32'(Tx_DATA), 32'(e.data));
            chk("grant_id", 32'(sif.grant_id), 32'(e.id));
            cur_data  = e.data;
            ack_cyc   = cyc;
            busy_baud = baud_select;
          end
          if (kind_o == 2) chk("timeout_latency", 32'(cyc), 32'(wr_cyc + TO + 1));
        end
      end
      if (sif.req_ack == 4'b0 && sif.sched_busy) begin
        chk("baud_stable", 32'(baud_select), 32'(busy_baud));
        chk("tx_en_frame", 32'(Tx_EN), 32'd1);
      end
      if (Tx_WR) begin
        chk("wr_latency", 32'(cyc), 32'(ack_cyc + 1));
        wr_cyc = cyc;
      end
      if (rx_valid) chk("rx_data", 32'(rx_data), 32'(cur_data));
    end
  end

  // Bounded wait: 0 = ack pulse, 1 = scheduler idle, 2 = Tx_BUSY high.
  task automatic wait_cond(input int which, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((which == 0 && sif.req_ack != 4'b0) || (which == 1 && !sif.sched_busy) ||
          (which == 2 && Tx_BUSY)) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_timeout: condition %0d not seen in %0d cycles, required within bound", which, bound);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ack"}, 32'(sif.req_ack), 32'd0);
    chk({tag, "_tx_done"}, 32'(sif.tx_done), 32'd0);
    chk({tag, "_tx_err"}, 32'(sif.tx_err), 32'd0);
    chk({tag, "_grant_id"}, 32'(sif.grant_id), 32'(N - 1));
    chk({tag, "_sched_busy"}, 32'(sif.sched_busy), 32'd0);
    chk({tag, "_Tx_DATA"}, 32'(Tx_DATA), 32'h00);
    chk({tag, "_Tx_WR"}, 32'(Tx_WR), 32'd0);
    chk({tag, "_Tx_EN"}, 32'(Tx_EN), 32'd0);
    chk({tag, "_baud_select"}, 32'(baud_select), 32'd0);
  endtask

  // Hold mask until k grants have been acknowledged, then drop it.
  task automatic run_phase(input logic [N-1:0] mask, input int k, input bit to_mode,
                           input logic [31:0] data);
    bit ok;
    int id;
    exp_t e;
    for (int j = 0; j < k; j++) begin
      id = next_grant(mask, mptr);
      e.kind = 2'd0; e.id = 3'(id); e.data = 8'(data >> (8 * id));
      exp_q.push_back(e);
      e.kind = to_mode ? 2'd2 : 2'd1; e.data = 8'h00;
      exp_q.push_back(e);
      mptr = id;
    end
    no_busy      = to_mode;
    sif.req_data = data;
    sif.req      = mask;
    enable       = 1'b1;
    for (int j = 0; j < k; j++) begin
      wait_cond(0, 300, ok);
      if (!ok) break;
      if (j == k - 1) sif.req = 4'b0;
    end
    sif.req = 4'b0;
    wait_cond(1, 300, ok);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    no_busy = 1'b0;
  endtask

  initial begin : stimulus
    bit ok;
    exp_t e;
    sif.req = 4'b0; sif.req_data = 32'h0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    baud_cfg = 3'b010;
    repeat (2) @(negedge clk);

    // Fairness from a fresh pointer: expect 0,1,2,3,0.
    run_phase(4'b1111, 5, 1'b0, 32'hA3A2A1A0);
    // Single requester with 8'h6C, re-granted on consecutive passes.
    run_phase(4'b0001, 2, 1'b0, {$urandom_range(0, 32'hFFFFFF), 8'h6C} );
    chk("baud_select_idle", 32'(baud_select), 32'd2);
    // Wrap and skip: serve 2, then 0 and 1.
    run_phase(4'b0100, 1, 1'b0, $urandom());
    run_phase(4'b0011, 2, 1'b0, $urandom());
    // Randomised masks and counts.
    for (int r = 0; r < 8; r++)
      run_phase(4'($urandom_range(1, 15)), int'($urandom_range(1, 3)), 1'b0, $urandom());
    // Transmitter never goes busy.
    run_phase(4'b0010, 1, 1'b1, $urandom());

    // Mid-frame configuration change.
    e.kind = 2'd0; e.id = 3'd0; e.data = 8'h5A; exp_q.push_back(e);
    e.kind = 2'd1; e.data = 8'h00;              exp_q.push_back(e);
    mptr = 0;
    sif.req_data = 32'h1122335A;
    sif.req = 4'b0001;
    wait_cond(0, 100, ok);
    wait_cond(2, 100, ok);
    @(negedge clk);
    baud_cfg = 3'b111;
    enable   = 1'b0;
    chk("baud_hold_midframe", 32'(baud_select), 32'd2);
    wait_cond(1, 100, ok);
    repeat (5) @(negedge clk);
    chk("tx_en_after_disable", 32'(Tx_EN), 32'd0);
    chk("baud_after_idle", 32'(baud_select), 32'd7);
    chk("no_grant_disabled", 32'(sif.sched_busy), 32'd0);
    chk("midframe_queue", 32'(exp_q.size()), 32'd0);
    sif.req = 4'b0;

    // Reset during WAIT_DONE: ack only, no done afterwards.
    enable = 1'b1; baud_cfg = 3'b010;
    repeat (2) @(negedge clk);
    e.kind = 2'd0; e.id = 3'(next_grant(4'b1000, mptr)); e.data = 8'hC3; exp_q.push_back(e);
    sif.req_data = 32'hC3000000;
    sif.req = 4'b1000;
    wait_cond(0, 100, ok);
    wait_cond(2, 100, ok);
    @(negedge clk);
    reset = 1'b0;
    sif.req = 4'b0;
    #1;
    check_reset_vals("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mptr = N - 1;
    repeat (40) @(negedge clk);
    chk("no_done_after_reset", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Recovery after reset.
    run_phase(4'b1010, 3, 1'b0, $urandom());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #300000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
